// File: rtl/serial_parity_receiver.sv
// rtl/serial_parity_receiver.sv - serial frame deserialiser with XOR parity check and valid/ready output (optional SERIAL_PARITY_RECEIVER_ERRCNT_EN error counter)
module serial_parity_receiver #(
    parameter int DATA_W     = 8,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sdi,
    input  logic              sdi_valid,
    input  logic              sof,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              overrun,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic              start;
    logic              frame_done;
    logic              exp_parity;
    logic              err_now;
    logic [DATA_W-1:0] first_word;
    logic [DATA_W-1:0] bit_word;

    // A start beat is only meaningful when it is qualified by sdi_valid.
    assign start      = sdi_valid & sof;
    assign first_word = {{(DATA_W-1){1'b0}}, sdi};
    assign bit_word   = sdi ? (DATA_W'(1) << cnt) : '0;
    assign exp_parity = (^shreg) ^ ODD_PARITY;
    assign err_now    = sdi ^ exp_parity;

    // Next-state, counter and shift-register update for the frame FSM.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_W'(1);
                    shreg_nxt = first_word;
                end
            end
            ST_DATA: begin
                if (start) begin
                    // Restart: drop the partial frame, this beat is bit 0.
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_W'(1);
                    shreg_nxt = first_word;
                end else if (sdi_valid) begin
                    // Target bit is still zero since the frame start cleared it.
                    shreg_nxt = shreg | bit_word;
                    cnt_nxt   = cnt + CNT_W'(1);
                    if (cnt == LAST_IDX) begin
                        state_nxt = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (start) begin
                    state_nxt = ST_DATA;
                    cnt_nxt   = CNT_W'(1);
                    shreg_nxt = first_word;
                end else if (sdi_valid) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_IDLE;
                    cnt_nxt    = '0;
                    shreg_nxt  = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
            end
        endcase
    end

    // Frame FSM state registers; busy is registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Output holding register with valid/ready handshake and overrun tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else if (frame_done) begin
            // A pending word not taken this cycle is lost to the new one.
            dout       <= shreg;
            parity_err <= err_now;
            dout_valid <= 1'b1;
            overrun    <= dout_valid & ~dout_ready;
        end else if (dout_valid && dout_ready) begin
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
        end
    end

`ifdef SERIAL_PARITY_RECEIVER_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of completed frames whose parity check failed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (frame_done && err_now && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'd0;
`endif

endmodule
